// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the ID-stage register scoreboard: default sizes,
// producer latency encodings and the hardwired-zero register address.
package id_scoreboard_pkg;

  // Default geometry of the register file and scoreboard
  localparam int unsigned NREG_DEF   = 32;
  localparam int unsigned AW_DEF     = 5;
  localparam int unsigned LAT_W_DEF  = 3;
  localparam int unsigned NUM_RD_DEF = 2;

  // Producer latency encodings: cycles after issue before the result is forwardable
  localparam logic [2:0] LAT_ALU  = 3'd0;
  localparam logic [2:0] LAT_LOAD = 3'd1;
  localparam logic [2:0] LAT_MUL  = 3'd3;

  // Register 0 reads as zero, is never tracked and never hazards
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_scoreboard_entry.sv
// One scoreboard entry: pending flag plus latency countdown for a single
// architectural register. Set beats clear, clear beats decrement.
module sb_entry
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active-low
  input  logic             set_en,    // an issuing instruction writes this register
  input  logic [LAT_W-1:0] set_lat,   // latency of that producer
  input  logic             clr_en,    // writeback retires this register
  input  logic             dec_en,    // count one cycle of producer progress
  output logic             pending,
  output logic [LAT_W-1:0] cnt
);

  logic             pending_r;
  logic [LAT_W-1:0] cnt_r;

  // Entry state update: issue wins over a same-cycle writeback and decrement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= 1'b0;
      cnt_r     <= '0;
    end else if (set_en) begin
      pending_r <= 1'b1;
      cnt_r     <= set_lat;
    end else if (clr_en) begin
      pending_r <= 1'b0;
      cnt_r     <= '0;
    end else if (dec_en && (cnt_r != '0)) begin
      pending_r <= pending_r;
      cnt_r     <= cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
    end else begin
      pending_r <= pending_r;
      cnt_r     <= cnt_r;
    end
  end

  assign pending = pending_r;
  assign cnt     = cnt_r;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: tracks in-flight register writes with per-register
// latency countdowns, raises a stall request on RAW/WAW hazards, produces the
// issue strobe and selects forwarding for operands whose producer is ready.
// All outputs are combinational from the current state and ID inputs.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,        // asynchronous, active-low
  input  logic                 id_valid,
  input  logic [NUM_RD*AW-1:0] id_rs_addr,
  input  logic [NUM_RD-1:0]    id_rs_used,
  input  logic [AW-1:0]        id_dst_addr,
  input  logic                 id_gpr_we_,   // active-low destination write enable
  input  logic [LAT_W-1:0]     id_lat,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  output logic                 issue,
  output logic                 ld_hazard,
  output logic [NUM_RD-1:0]    fwd_sel,
  output logic                 sb_idle
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  // Full-width views of the scoreboard; slot 0 is a constant idle entry so
  // lookups by address need no special case for register 0.
  logic [NREG-1:0]  pend_s;
  logic [LAT_W-1:0] cnt_s [NREG];
  logic [AW-1:0]    rs_a_s [NUM_RD];

  logic [NUM_RD-1:0] rs_busy_s;
  logic [NUM_RD-1:0] fwd_s;
  logic              dst_busy_s;
  logic              hazard_s;
  logic              issue_s;
  logic              dst_we_s;

  assign pend_s[0] = 1'b0;
  assign cnt_s[0]  = '0;
  assign dst_we_s  = !id_gpr_we_ && (id_dst_addr != ZERO_ADDR);

  genvar gk;
  generate
    for (gk = 0; gk < NUM_RD; gk++) begin : g_rs
      assign rs_a_s[gk] = id_rs_addr[gk*AW +: AW];
    end
  endgenerate

  genvar gr;
  generate
    for (gr = 1; gr < NREG; gr++) begin : g_entry
      logic set_s;
      logic clr_s;
      logic dec_s;

      assign set_s = issue_s && dst_we_s && (id_dst_addr == AW'(gr));
      assign clr_s = wb_valid && (wb_addr == AW'(gr));
      assign dec_s = pend_s[gr] && (cnt_s[gr] != '0);

      sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_s),
        .set_lat (id_lat),
        .clr_en  (clr_s),
        .dec_en  (dec_s),
        .pending (pend_s[gr]),
        .cnt     (cnt_s[gr])
      );
    end
  endgenerate

  // Per-operand hazard and forward select: pending with count left stalls,
  // pending with count exhausted takes the forwarding network
  always_comb begin
    rs_busy_s = '0;
    fwd_s     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (id_rs_used[k] && (rs_a_s[k] != ZERO_ADDR) && pend_s[rs_a_s[k]]) begin
        if (cnt_s[rs_a_s[k]] != '0) begin
          rs_busy_s[k] = 1'b1;
          fwd_s[k]     = 1'b0;
        end else begin
          rs_busy_s[k] = 1'b0;
          fwd_s[k]     = 1'b1;
        end
      end else begin
        rs_busy_s[k] = 1'b0;
        fwd_s[k]     = 1'b0;
      end
    end
  end

  // WAW guard: a younger write must not overtake an older in-flight one
  always_comb begin
    dst_busy_s = 1'b0;
    if (dst_we_s && pend_s[id_dst_addr] && (cnt_s[id_dst_addr] != '0)) begin
      dst_busy_s = 1'b1;
    end else begin
      dst_busy_s = 1'b0;
    end
  end

  // Stall request and issue strobe; stall and flush only hold the instruction
  always_comb begin
    hazard_s = id_valid && ((|rs_busy_s) || dst_busy_s);
    issue_s  = id_valid && !hazard_s && !stall && !flush;
  end

  assign ld_hazard = hazard_s;
  assign issue     = issue_s;
  assign fwd_sel   = fwd_s;
  assign sb_idle   = ~|pend_s;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus a random
// phase. Expected outputs come from a small behavioural register model and
// are queued when stimulus is applied, then popped and compared mid-cycle.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_lat;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        issue;
  logic        ld_hazard;
  logic [1:0]  fwd_sel;
  logic        sb_idle;

  typedef struct {
    logic       iss;
    logic       ld;
    logic [1:0] fwd;
    logic       idle;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of the register state
  logic       m_pend [32];
  logic [2:0] m_cnt  [32];

  int n_tests = 0;
  int n_fail  = 0;

  logic obs_iss, obs_ld, obs_idle;
  logic [1:0] obs_fwd;

  id_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rs_used  (id_rs_used),
    .id_dst_addr (id_dst_addr),
    .id_gpr_we_  (id_gpr_we_),
    .id_lat      (id_lat),
    .stall       (stall),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .issue       (issue),
    .ld_hazard   (ld_hazard),
    .fwd_sel     (fwd_sel),
    .sb_idle     (sb_idle)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_pend[r] = 1'b0;
      m_cnt[r]  = 3'd0;
    end
  endtask

  function automatic logic m_busy(input logic [4:0] a);
    return (a != 5'd0) && m_pend[a] && (m_cnt[a] != 3'd0);
  endfunction

  // One ID cycle: apply inputs just after a rising edge, queue the expected
  // outputs, compare mid-cycle, then advance the model across the next edge.
  task automatic step(input string tag, input logic v, input logic [4:0] rs0,
                      input logic [4:0] rs1, input logic [1:0] used,
                      input logic [4:0] dst, input logic wen_n, input logic [2:0] lat,
                      input logic st, input logic fl, input logic wbv,
                      input logic [4:0] wba);
    exp_t e;
    exp_t o;
    logic [4:0] rs [2];
    logic busy;
    id_valid    = v;
    id_rs_addr  = {rs1, rs0};
    id_rs_used  = used;
    id_dst_addr = dst;
    id_gpr_we_  = wen_n;
    id_lat      = lat;
    stall       = st;
    flush       = fl;
    wb_valid    = wbv;
    wb_addr     = wba;
    if (!reset) model_clear();
    rs[0] = rs0;
    rs[1] = rs1;
    busy  = (!wen_n) && m_busy(dst);
    e.fwd = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (used[k] && m_busy(rs[k])) busy = 1'b1;
      if (used[k] && (rs[k] != 5'd0) && m_pend[rs[k]] && (m_cnt[rs[k]] == 3'd0)) e.fwd[k] = 1'b1;
    end
    e.ld   = v && busy;
    e.iss  = v && !e.ld && !st && !fl;
    e.idle = 1'b1;
    for (int r = 1; r < 32; r++) if (m_pend[r]) e.idle = 1'b0;
    exp_q.push_back(e);
    #3;
    o = exp_q.pop_front();
    obs_iss  = issue;
    obs_ld   = ld_hazard;
    obs_fwd  = fwd_sel;
    obs_idle = sb_idle;
    check({tag, "/issue"},     {31'd0, obs_iss},  {31'd0, o.iss});
    check({tag, "/ld_hazard"}, {31'd0, obs_ld},   {31'd0, o.ld});
    check({tag, "/fwd_sel"},   {30'd0, obs_fwd},  {30'd0, o.fwd});
    check({tag, "/sb_idle"},   {31'd0, obs_idle}, {31'd0, o.idle});
    @(posedge clk);
    if (reset) begin
      for (int r = 1; r < 32; r++) begin
        if (e.iss && !wen_n && (dst == 5'(r))) begin
          m_pend[r] = 1'b1;
          m_cnt[r]  = lat;
        end else if (wbv && (wba == 5'(r))) begin
          m_pend[r] = 1'b0;
          m_cnt[r]  = 3'd0;
        end else if (m_pend[r] && (m_cnt[r] != 3'd0)) begin
          m_cnt[r] = m_cnt[r] - 3'd1;
        end
      end
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    step(tag, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic wb_cycle(input string tag, input logic [4:0] a);
    step(tag, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, a);
  endtask

  initial begin
    int hz;
    int k;
    logic [4:0] wa;
    model_clear();
    reset = 1'b0;
    id_valid = 1'b0; id_rs_addr = 10'd0; id_rs_used = 2'b00; id_dst_addr = 5'd0;
    id_gpr_we_ = 1'b1; id_lat = 3'd0; stall = 1'b0; flush = 1'b0;
    wb_valid = 1'b0; wb_addr = 5'd0;
    @(posedge clk);
    #1;

    // Outputs while reset is held
    step("rst_hold", 1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("rst_issue", {31'd0, obs_iss}, 32'd1);
    reset = 1'b1;

    // Nothing pending: read x5 issues freely
    step("free", 1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("free_idle", {31'd0, obs_idle}, 32'd1);

    // Load to x5, consumer one bubble behind
    step("ld_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b0, LAT_LOAD, 1'b0, 1'b0, 1'b0, 5'd0);
    step("ld_t1", 1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("ld_t1_hz", {31'd0, obs_ld}, 32'd1);
    step("ld_t2", 1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("ld_t2_iss", {31'd0, obs_iss}, 32'd1);
    check("ld_t2_fwd", {30'd0, obs_fwd}, 32'd1);
    wb_cycle("ld_wb", 5'd5);

    // MUL to x7, consumer waiting on port 1
    step("mul_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b0, LAT_MUL, 1'b0, 1'b0, 1'b0, 5'd0);
    hz = 0;
    k  = 0;
    obs_iss = 1'b0;
    while (!obs_iss && (k < 8)) begin
      step("mul_use", 1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      if (obs_ld) hz++;
      k++;
    end
    check("mul_hz_cycles", hz, 32'd3);
    check("mul_fwd", {30'd0, obs_fwd}, 32'd2);
    idle_cycle("mul_gap");
    wb_cycle("mul_wb", 5'd7);
    idle_cycle("mul_after");
    check("mul_idle", {31'd0, obs_idle}, 32'd1);

    // Same-cycle issue and writeback to x9: issue wins
    step("x9_both", 1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 5'd9);
    step("x9_use", 1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("x9_hz", {31'd0, obs_ld}, 32'd1);
    check("x9_busy", {31'd0, obs_idle}, 32'd0);
    idle_cycle("x9_drain");
    wb_cycle("x9_wb", 5'd9);

    // Register 0 is never tracked
    step("x0_wr", 1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0);
    step("x0_rd", 1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("x0_idle", {31'd0, obs_idle}, 32'd1);
    check("x0_fwd", {30'd0, obs_fwd}, 32'd0);

    // Flush held across a hazard: countdown continues on schedule
    step("fl_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b0, LAT_MUL, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step("fl_hold", 1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
      check("fl_hold_iss", {31'd0, obs_iss}, 32'd0);
    end
    step("fl_go", 1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("fl_go_hz", {31'd0, obs_ld}, 32'd0);
    check("fl_go_iss", {31'd0, obs_iss}, 32'd1);
    wb_cycle("fl_wb", 5'd11);

    // WAW: second writer of x12 waits for the first
    step("waw_1", 1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 5'd0);
    step("waw_2", 1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, LAT_ALU, 1'b0, 1'b0, 1'b0, 5'd0);
    check("waw_hz", {31'd0, obs_ld}, 32'd1);
    step("waw_3", 1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, LAT_ALU, 1'b0, 1'b0, 1'b0, 5'd0);
    step("waw_4", 1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b0, LAT_ALU, 1'b0, 1'b0, 1'b0, 5'd0);
    check("waw_iss", {31'd0, obs_iss}, 32'd1);
    wb_cycle("waw_wb", 5'd12);

    // Reset asserted mid-countdown on x3
    step("rc_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0);
    idle_cycle("rc_tick");
    reset = 1'b0;
    step("rc_use", 1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("rc_idle", {31'd0, obs_idle}, 32'd1);
    check("rc_hz", {31'd0, obs_ld}, 32'd0);
    reset = 1'b1;

    // Random traffic on a small register window; writeback only when legal
    for (int i = 0; i < 300; i++) begin
      wa = 5'($urandom_range(7, 1));
      step("rand",
           1'($urandom_range(1, 0)),
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           2'($urandom_range(3, 0)),
           5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
           3'($urandom_range(7, 0)),
           1'($urandom_range(7, 0) == 0), 1'($urandom_range(7, 0) == 0),
           m_pend[wa] && (m_cnt[wa] == 3'd0) && 1'($urandom_range(1, 0)), wa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
